// File: rtl/match_ctrl_pkg.sv
// Shared definitions for the match sequencer: state codes, keyboard scan codes,
// parameter defaults and small decode helpers.
package match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam int WIN_SCORE_DEF    = 7;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int POINT_FRAMES_DEF = 90;

  // A make code only counts when the byte before it was not a break prefix.
  function automatic logic key_event(input logic rx, input logic [15:0] hist,
                                     input logic [7:0] code);
    return rx && (hist[7:0] == code) && (hist[15:8] != SC_BREAK);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/match_ctrl_frame_timer.sv
// Loadable 8-bit frame down-counter; done is high while the count is zero.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       frame_tick,
  output logic       done
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (frame_tick && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 8'd0);

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer for a two-player paddle game: keyboard start/abort, serve delay,
// point scoring and match-over detection.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        RX_Done,
  input  logic        frame_tick,
  input  logic        miss_left,
  input  logic        miss_right,
  output logic        start_Match,
  output logic        play_En,
  output logic        pos_Rst,
  output logic        serve_Dir,
  output logic [3:0]  score_L,
  output logic [3:0]  score_R,
  output logic        match_Ended,
  output logic [2:0]  state
);

  localparam logic [3:0] WinV   = 4'(WIN_SCORE);
  localparam logic [7:0] ServeV = 8'(SERVE_FRAMES);
  localparam logic [7:0] PointV = 8'(POINT_FRAMES);

  state_e     state_q;
  logic [3:0] score_l_q, score_r_q;
  logic       serve_dir_q, start_q;
  logic       space_ev, esc_ev, abort, won;
  logic       tmr_load, tmr_done;
  logic [7:0] tmr_val;
  logic       unused_data;

  assign unused_data = ^data[31:16];
  assign space_ev    = key_event(RX_Done, data[15:0], SC_SPACE);
  assign esc_ev      = key_event(RX_Done, data[15:0], SC_ESC);
  assign abort       = esc_ev && (state_q != ST_IDLE);
  assign won         = (score_l_q == WinV) || (score_r_q == WinV);

  // The timer is loaded on the same edge that enters SERVE or POINT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = ServeV;
    if (!abort) begin
      case (state_q)
        ST_IDLE:  tmr_load = space_ev;
        ST_PLAY: begin
          tmr_load = miss_left || miss_right;
          tmr_val  = PointV;
        end
        ST_POINT: tmr_load = tmr_done && !won;
        default:  tmr_load = 1'b0;
      endcase
    end
  end

  frame_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .frame_tick(frame_tick),
    .done      (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_dir_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (abort) begin
        state_q   <= ST_IDLE;
        score_l_q <= 4'd0;
        score_r_q <= 4'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (space_ev) begin
              state_q     <= ST_SERVE;
              start_q     <= 1'b1;
              score_l_q   <= 4'd0;
              score_r_q   <= 4'd0;
              serve_dir_q <= 1'b0;
            end
          end
          ST_SERVE: begin
            if (tmr_done) state_q <= ST_PLAY;
          end
          // Scoring happens only on the PLAY exit, so a held miss counts once.
          ST_PLAY: begin
            if (miss_left) begin
              score_r_q   <= sat_inc(score_r_q, WinV);
              serve_dir_q <= 1'b0;
              state_q     <= ST_POINT;
            end else if (miss_right) begin
              score_l_q   <= sat_inc(score_l_q, WinV);
              serve_dir_q <= 1'b1;
              state_q     <= ST_POINT;
            end
          end
          ST_POINT: begin
            if (tmr_done) state_q <= won ? ST_OVER : ST_SERVE;
          end
          ST_OVER: begin
            if (space_ev) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign state       = state_q;
  assign start_Match = start_q;
  assign serve_Dir   = serve_dir_q;
  assign score_L     = score_l_q;
  assign score_R     = score_r_q;
  assign play_En     = (state_q == ST_PLAY);
  assign pos_Rst     = !((state_q == ST_PLAY) || (state_q == ST_POINT));
  assign match_Ended = (state_q == ST_OVER);

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a tick-counting reference model.
module tb_match_ctrl;

  localparam int WIN = 2;
  localparam int SF  = 3;
  localparam int PF  = 2;
  localparam logic [15:0] RESET_VEC = 16'h0002;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        RX_Done, frame_tick, miss_left, miss_right;
  logic        start_Match, play_En, pos_Rst, serve_Dir, match_Ended;
  logic [3:0]  score_L, score_R;
  logic [2:0]  state;

  always #5 clk = ~clk;

  match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clk(clk), .rst(rst), .data(data), .RX_Done(RX_Done), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .start_Match(start_Match),
    .play_En(play_En), .pos_Rst(pos_Rst), .serve_Dir(serve_Dir), .score_L(score_L),
    .score_R(score_R), .match_Ended(match_Ended), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode number, scores, serve side and frames seen in current mode.
  int   m_state, m_sl, m_sr, m_ticks;
  logic m_dir, m_start;

  function automatic logic [15:0] dut_vec();
    return {state, score_L, score_R, serve_Dir, start_Match, play_En, pos_Rst, match_Ended};
  endfunction

  function automatic logic [15:0] model_vec();
    logic pr;
    pr = (m_state == 0) || (m_state == 1) || (m_state == 4);
    return {3'(m_state), 4'(m_sl), 4'(m_sr), m_dir, m_start, (m_state == 2), pr, (m_state == 4)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_sl = 0; m_sr = 0; m_ticks = 0; m_dir = 1'b0; m_start = 1'b0;
  endfunction

  function automatic void model_step(input logic rx, input logic [15:0] d, input logic tk,
                                     input logic ml, input logic mr);
    logic space, esc;
    space = rx && (d[7:0] == 8'h29) && (d[15:8] != 8'hF0);
    esc   = rx && (d[7:0] == 8'h76) && (d[15:8] != 8'hF0);
    m_start = 1'b0;
    if (esc && m_state != 0) begin
      m_state = 0; m_sl = 0; m_sr = 0;
    end else begin
      case (m_state)
        0: if (space) begin
             m_state = 1; m_start = 1'b1; m_sl = 0; m_sr = 0; m_dir = 1'b0; m_ticks = 0;
           end
        1: if (m_ticks >= SF) m_state = 2;
           else if (tk) m_ticks++;
        2: if (ml) begin
             if (m_sr < WIN) m_sr++;
             m_dir = 1'b0; m_state = 3; m_ticks = 0;
           end else if (mr) begin
             if (m_sl < WIN) m_sl++;
             m_dir = 1'b1; m_state = 3; m_ticks = 0;
           end
        3: if (m_ticks >= PF) begin
             if (m_sl == WIN || m_sr == WIN) m_state = 4;
             else begin m_state = 1; m_ticks = 0; end
           end else if (tk) m_ticks++;
        4: if (space) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endfunction

  task automatic step(input logic rx, input logic [15:0] d, input logic tk,
                      input logic ml, input logic mr);
    RX_Done = rx; data = {16'($urandom()), d}; frame_tick = tk;
    miss_left = ml; miss_right = mr;
    @(posedge clk);
    model_step(rx, d, tk, ml, mr);
    #1;
  endtask

  task automatic sync_reset();
    RX_Done = 0; data = 0; frame_tick = 0; miss_left = 0; miss_right = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic to_play();
    step(1, 16'h0029, 0, 0, 0);
    for (int i = 0; i < SF; i++) step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; RX_Done = 0; data = 0; frame_tick = 0; miss_left = 0; miss_right = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_vec(), RESET_VEC);
    end
    rst = 1'b0;
    model_reset();
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 1, 1, 1);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL idle_hold got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_start();
    int pulses;
    step(1, 16'h0029, 0, 0, 0);
    pulses = int'(start_Match);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0, 0, 0, 0);
      pulses += int'(start_Match);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL start_pulse_count got %0d want 1", pulses);
    end
    checks++;
    if (state !== 3'd1 || score_L !== 4'd0 || score_R !== 4'd0) begin
      errors++; $display("FAIL start_state got %0d/%0d/%0d want 1/0/0", state, score_L, score_R);
    end
  endtask

  task automatic test_serve();
    for (int i = 0; i < SF; i++) begin
      step(0, 16'h0, 1, 0, 0);
      step(0, 16'h0, 0, 0, 0);
      if (i == SF - 1) break;
      checks++;
      if (state !== 3'd1) begin
        errors++; $display("FAIL serve_wait got %0d want 1", state);
      end
    end
    checks++;
    if (state !== 3'd2 || play_En !== 1'b1 || pos_Rst !== 1'b0) begin
      errors++; $display("FAIL serve_to_play got st=%0d pe=%b pr=%b want 2/1/0", state, play_En, pos_Rst);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL serve_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_miss_right();
    for (int i = 0; i < 5; i++) step(0, 16'h0, 0, 0, 1);
    checks++;
    if (score_L !== 4'd1 || score_R !== 4'd0 || serve_Dir !== 1'b1 || state !== 3'd3) begin
      errors++; $display("FAIL miss_right got L=%0d R=%0d dir=%b st=%0d want 1/0/1/3",
                         score_L, score_R, serve_Dir, state);
    end
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL point_hold got %0d want 3", state);
    end
    step(0, 16'h0, 0, 0, 0);
    checks++;
    if (state !== 3'd1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL point_to_serve got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_double_miss();
    sync_reset();
    to_play();
    step(0, 16'h0, 0, 1, 1);
    step(0, 16'h0, 0, 1, 1);
    checks++;
    if (score_R !== 4'd1 || score_L !== 4'd0 || serve_Dir !== 1'b0) begin
      errors++; $display("FAIL both_miss_1 got L=%0d R=%0d dir=%b want 0/1/0", score_L, score_R, serve_Dir);
    end
    for (int i = 0; i < PF; i++) step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < SF; i++) step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 1, 1);
    checks++;
    if (score_R !== 4'd2 || score_L !== 4'd0 || state !== 3'd3) begin
      errors++; $display("FAIL both_miss_2 got L=%0d R=%0d st=%0d want 0/2/3", score_L, score_R, state);
    end
    for (int i = 0; i < PF; i++) step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    checks++;
    if (state !== 3'd4 || match_Ended !== 1'b1 || pos_Rst !== 1'b1) begin
      errors++; $display("FAIL over got st=%0d me=%b pr=%b want 4/1/1", state, match_Ended, pos_Rst);
    end
    step(1, 16'h0029, 1, 0, 0);
    checks++;
    if (state !== 3'd0 || score_R !== 4'd2 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL over_to_idle got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_break_esc();
    sync_reset();
    to_play();
    step(0, 16'h0, 0, 0, 1);
    for (int i = 0; i < PF; i++) step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < SF; i++) step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    step(1, 16'hF029, 0, 0, 0);
    checks++;
    if (state !== 3'd2 || score_L !== 4'd1) begin
      errors++; $display("FAIL break_ignored got st=%0d L=%0d want 2/1", state, score_L);
    end
    step(1, 16'hF076, 0, 0, 0);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL break_esc_ignored got %0d want 2", state);
    end
    step(1, 16'h0076, 0, 1, 0);
    checks++;
    if (state !== 3'd0 || score_L !== 4'd0 || score_R !== 4'd0 || pos_Rst !== 1'b1) begin
      errors++; $display("FAIL esc_abort got st=%0d L=%0d R=%0d pr=%b want 0/0/0/1",
                         state, score_L, score_R, pos_Rst);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    sync_reset();
    to_play();
    step(0, 16'h0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++; $display("FAIL async_reset got %h want %h", dut_vec(), RESET_VEC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0, 1, 0, 0);
      pulses += int'(start_Match);
    end
    checks++;
    if (pulses !== 0 || state !== 3'd0) begin
      errors++; $display("FAIL post_reset got pulses=%0d st=%0d want 0/0", pulses, state);
    end
  endtask

  task automatic test_random();
    logic        ml, mr, rx, tk;
    logic [15:0] d;
    int          sel, shown;
    sync_reset();
    ml = 0; mr = 0; shown = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) ml = ~ml;
      if ($urandom_range(0, 7) == 0) mr = ~mr;
      tk  = ($urandom_range(0, 1) == 1);
      rx  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 15);
      if (sel < 8)        d = 16'h0029;
      else if (sel < 10)  d = 16'hF029;
      else if (sel == 10) d = 16'h0076;
      else if (sel == 11) d = 16'hF076;
      else                d = 16'($urandom());
      step(rx, d, tk, ml, mr);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d got %h want %h", c, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_serve();
    test_miss_right();
    test_double_miss();
    test_break_esc();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning the points that end a match (legal range 1..15).
REQ-002 The block SHALL have parameter SERVE_FRAMES, default 60, meaning the frames held in SERVE before play (range 1..255).
REQ-003 The block SHALL have parameter POINT_FRAMES, default 90, meaning the frames held in POINT after a miss (range 1..255).
REQ-004 Port clk: input, 1 bit, the single system clock.
REQ-005 Port rst: input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-006 Port data: input, 32 bits, the keyboard scan-byte history; data[7:0] is the newest byte and data[15:8] the previous byte.
REQ-007 Port RX_Done: input, 1 bit, a one-cycle pulse when a new scan byte has been shifted into data.
REQ-008 Port frame_tick: input, 1 bit, a one-cycle pulse once per video frame.
REQ-009 Ports miss_left / miss_right: inputs, 1 bit each, level-high while the ball is beyond the left/right game bound.
REQ-010 Port start_Match: output, 1 bit, a one-cycle pulse when a match starts.
REQ-011 Port play_En: output, 1 bit, enables paddle and ball motion.
REQ-012 Port pos_Rst: output, 1 bit, holds paddles and ball at their centre positions.
REQ-013 Port serve_Dir: output, 1 bit, the serve direction (0 = toward left player, 1 = toward right player).
REQ-014 Ports score_L / score_R: outputs, 4 bits each, the players' points.
REQ-015 Port match_Ended: output, 1 bit, high while in OVER.
REQ-016 Port state: output, 3 bits, the current state code, for debug.

Function
REQ-017 The block SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; codes 5..7 SHALL go to IDLE on the next clk.
REQ-018 A space event SHALL be RX_Done=1 with data[7:0]=8'h29 and data[15:8]!=8'hF0; an Esc event SHALL be the same with 8'h76; break sequences (F0 xx) SHALL be ignored.
REQ-019 IDLE: pos_Rst=1, play_En=0; on a space event go to SERVE, pulse start_Match for exactly one cycle, clear both scores, set serve_Dir=0.
REQ-020 SERVE: pos_Rst=1, play_En=0; load the timer with SERVE_FRAMES on entry; decrement on each frame_tick; enter PLAY on the clk after the tick that reaches 0.
REQ-021 PLAY: pos_Rst=0, play_En=1. On miss_left=1: score_R+1, serve_Dir<=0, go to POINT. On miss_right=1: score_L+1, serve_Dir<=1, go to POINT.
REQ-022 If miss_left and miss_right are both high in the same cycle, only miss_left SHALL be honoured.
REQ-023 Each miss SHALL score exactly once, because scoring occurs only on the PLAY exit edge; a miss level that persists into POINT or SERVE SHALL be ignored.
REQ-024 POINT: play_En=0, pos_Rst=0; load the timer with POINT_FRAMES on entry. At expiry, go to OVER if score_L==WIN_SCORE or score_R==WIN_SCORE, else go to SERVE.
REQ-025 OVER: match_Ended=1, pos_Rst=1, play_En=0; scores held; on a space event go to IDLE (scores keep their value until the next start).
REQ-026 An Esc event in SERVE, PLAY, POINT or OVER SHALL go to IDLE, clear both scores, and override any same-cycle transition or scoring.
REQ-027 frame_tick and RX_Done coinciding SHALL both be processed in the same cycle.
REQ-028 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-029 All outputs SHALL be registered or decoded from the state register only; the transition latency SHALL be 1 clk.

Reset
REQ-030 On rst the block SHALL set: state=IDLE, score_L=score_R=0, serve_Dir=0, start_Match=0, timer=0, match_Ended=0, play_En=0, pos_Rst=1.
REQ-031 An rst mid-match SHALL abandon the match immediately, asynchronously, with no start_Match pulse.

Structure
REQ-032 The state codes, the scan codes 8'h29, 8'h76 and 8'hF0, and the parameter defaults SHALL live in the shared defines.v.
REQ-033 The block SHALL contain one sub-module, frame_timer: an 8-bit loadable down-counter with inputs load, load_val and frame_tick, and a done output.

Verification (bench params WIN_SCORE=2, SERVE_FRAMES=3, POINT_FRAMES=2)
REQ-034 Reset, then RX_Done with data[15:0]=16'h0029 -> exactly one start_Match pulse; state=1; scores 0.
REQ-035 In SERVE, issue 3 frame_ticks -> state=2 on the clk after the 3rd tick; play_En=1, pos_Rst=0.
REQ-036 In PLAY, hold miss_right high 5 cycles -> score_L=1 only, serve_Dir=1, state=3; after 2 ticks state=1.
REQ-037 Drive miss_left and miss_right together in PLAY twice -> score_R=2, score_L=0, then after 2 ticks state=4 and match_Ended=1; space event -> state=0.
REQ-038 In PLAY, send data[15:0]=16'hF029 -> no change; then send 16'h0076 -> state=0, scores 0, pos_Rst=1.
REQ-039 Assert rst in POINT, asynchronously between edges -> all outputs reach reset values before the next clk.
